// File: rtl/mmm_modexp_ctrl_if.sv
// mmm_modexp_ctrl_if: job request/response and Montgomery-multiplier bus of the modexp controller.
interface mmm_modexp_ctrl_if #(
  parameter int K = 256,
  parameter int E = 256
);
  logic         start;
  logic [K-1:0] base;
  logic [E-1:0] exp;
  logic [K-1:0] m;
  logic [K-1:0] r2;
  logic         busy;
  logic         done;
  logic [K-1:0] result;
  logic [K-1:0] mm_x;
  logic [K-1:0] mm_y;
  logic [K-1:0] mm_m;
  logic         mm_req;
  logic [K-1:0] mm_res;
  logic         mm_val;
  modport master (
    output start, base, exp, m, r2, mm_res, mm_val,
    input  busy, done, result, mm_x, mm_y, mm_m, mm_req
  );
  modport slave (
    input  start, base, exp, m, r2, mm_res, mm_val,
    output busy, done, result, mm_x, mm_y, mm_m, mm_req
  );
endinterface

// File: rtl/mmm_modexp_ctrl.sv
// mmm_modexp_ctrl: left-to-right square-and-multiply modexp sequencer driving an external
// Montgomery multiplier; every exponent bit is squared, set bits add one multiply.
module mmm_modexp_ctrl #(
  parameter int K = 256,
  parameter int E = 256
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mmm_modexp_ctrl_if.slave     bus
);
  localparam int IW = E > 1 ? $clog2(E) : 1;
  typedef enum logic [2:0] {IDLE, CONV_B, CONV_1, SQR, MUL, FROM, FIN} state_t;
  state_t         state_q, state_d;
  logic           wait_q, wait_d;
  logic [IW-1:0]  i_q, i_d;
  logic [K-1:0]   acc_q, acc_d, bm_q, bm_d, base_q, base_d, r2_q, r2_d, m_q, m_d, result_q, result_d;
  logic [E-1:0]   exp_q, exp_d;
  logic           op, fire, last;
  assign op   = state_q inside {CONV_B, CONV_1, SQR, MUL, FROM};
  assign fire = op && wait_q && bus.mm_val;
  assign last = i_q == '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wait_q   <= 1'b0;
      i_q      <= '0;
      acc_q    <= '0;
      bm_q     <= '0;
      base_q   <= '0;
      r2_q     <= '0;
      m_q      <= '0;
      exp_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      i_q      <= i_d;
      acc_q    <= acc_d;
      bm_q     <= bm_d;
      base_q   <= base_d;
      r2_q     <= r2_d;
      m_q      <= m_d;
      exp_q    <= exp_d;
      result_q <= result_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    i_d      = i_q;
    acc_d    = acc_q;
    bm_d     = bm_q;
    base_d   = base_q;
    r2_d     = r2_q;
    m_d      = m_q;
    exp_d    = exp_q;
    result_d = result_q;
    if (state_q == IDLE && bus.start) begin
      state_d = CONV_B;
      wait_d  = 1'b0;
      i_d     = IW'(E - 1);
      base_d  = bus.base;
      r2_d    = bus.r2;
      m_d     = bus.m;
      exp_d   = bus.exp;
    end
    if (op && !wait_q) wait_d = 1'b1;
    // re-entering an op state with wait cleared issues the next mm_req
    if (fire) begin
      wait_d = 1'b0;
      case (state_q)
        CONV_B: begin
          bm_d    = bus.mm_res;
          state_d = CONV_1;
        end
        CONV_1: begin
          acc_d   = bus.mm_res;
          state_d = SQR;
        end
        SQR: begin
          acc_d   = bus.mm_res;
          state_d = exp_q[i_q] ? MUL : last ? FROM : SQR;
          i_d     = (!exp_q[i_q] && !last) ? i_q - 1'b1 : i_q;
        end
        MUL: begin
          acc_d   = bus.mm_res;
          state_d = last ? FROM : SQR;
          i_d     = last ? i_q : i_q - 1'b1;
        end
        FROM: begin
          result_d = bus.mm_res;
          state_d  = FIN;
        end
        default: ;
      endcase
    end
    if (state_q == FIN) state_d = IDLE;
  end
  always_comb begin
    bus.busy   = state_q != IDLE;
    bus.done   = state_q == FIN;
    bus.mm_req = op && !wait_q;
    bus.mm_m   = m_q;
    bus.result = result_q;
    bus.mm_x   = state_q == CONV_B ? base_q : state_q == CONV_1 ? r2_q : op ? acc_q : '0;
    bus.mm_y   = state_q == CONV_B ? r2_q : state_q == SQR ? acc_q : state_q == MUL ? bm_q :
                 op ? K'(1) : '0;
  end
endmodule

// File: tb/tb_mmm_modexp_ctrl.sv
// tb_mmm_modexp_ctrl: randomized scoreboard bench with a behavioural Montgomery multiplier
// and a plain repeated-multiplication modexp reference.
module tb_mmm_modexp_ctrl;
  localparam int K = 16;
  localparam int E = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mmm_modexp_ctrl_if #(.K(K), .E(E)) bus ();
  mmm_modexp_ctrl #(.K(K), .E(E)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  longint sb_res[$];
  int sb_req[$];
  int req_cnt = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int lat_min = 5;
  int lat_max = 5;
  bit stale = 0;
  bit pend = 0;
  int cnt = 0;
  logic [K-1:0] cx, cy, cm;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask
  function automatic longint mont(input longint x, input longint y, input longint md);
    longint t = x * y;
    for (int j = 0; j < K; j++) begin
      if (t[0]) t += md;
      t = t >> 1;
    end
    return t >= md ? t - md : t;
  endfunction
  function automatic longint ref_exp(input longint b, input longint e, input longint md);
    longint r = 1 % md;
    for (longint j = 0; j < e; j++) r = (r * b) % md;
    return r;
  endfunction
  // behavioural multiplier: fixed or random latency, checks operand stability while pending
  always @(negedge clk) begin
    bus.mm_val = 1'b0;
    if (pend) begin
      if (!stale) begin
        chk("mm_operands_stable", {16'h0, bus.mm_x, bus.mm_y, bus.mm_m}, {16'h0, cx, cy, cm});
        chk("mm_req_while_pending", 64'(bus.mm_req), 64'h0);
      end
      cnt--;
      if (cnt == 0) begin
        bus.mm_res = K'(mont(longint'(cx), longint'(cy), longint'(cm)));
        bus.mm_val = 1'b1;
        pend = 0;
      end
    end else if (bus.mm_req) begin
      cx = bus.mm_x;
      cy = bus.mm_y;
      cm = bus.mm_m;
      pend = 1;
      cnt = $urandom_range(lat_max, lat_min);
    end
  end
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.mm_req) req_cnt++;
      if (bus.done) begin
        done_cnt++;
        if (sb_res.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done with empty scoreboard expected no done");
        end else begin
          chk("result", 64'(bus.result), 64'(sb_res.pop_front()));
          chk("mm_req_count", 64'(req_cnt), 64'(sb_req.pop_front()));
        end
        req_cnt = 0;
      end
    end
  end
  task automatic wait_idle(input int max);
    int n = 0;
    while (bus.busy && n < max) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) chk("idle_timeout", 64'(bus.busy), 64'h0);
  endtask
  task automatic issue(input logic [K-1:0] b, input logic [E-1:0] e, input logic [K-1:0] md);
    logic [63:0] two32 = 64'h1_0000_0000;
    bus.start = 1'b1;
    bus.base  = b;
    bus.exp   = e;
    bus.m     = md;
    bus.r2    = K'(two32 % 64'(md));
    sb_res.push_back(ref_exp(longint'(b), longint'(e), longint'(md)));
    sb_req.push_back(3 + E + $countones(e));
    exp_done++;
  endtask
  task automatic scramble();
    bus.start = 1'b0;
    bus.base  = K'($urandom);
    bus.exp   = E'($urandom);
    bus.m     = K'($urandom);
    bus.r2    = K'($urandom);
  endtask
  task automatic job(input logic [K-1:0] b, input logic [E-1:0] e, input logic [K-1:0] md);
    wait_idle(5000);
    issue(b, e, md);
    @(negedge clk);
    scramble();
    chk("busy_after_start", 64'(bus.busy), 64'h1);
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    int d0;
    bus.start = 1'b0; bus.base = '0; bus.exp = '0; bus.m = '0; bus.r2 = '0;
    bus.mm_res = '0; bus.mm_val = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'h0);
    chk("rst_done", 64'(bus.done), 64'h0);
    chk("rst_mm_req", 64'(bus.mm_req), 64'h0);
    chk("rst_result", 64'(bus.result), 64'h0);
    chk("rst_mm_x", 64'(bus.mm_x), 64'h0);
    chk("rst_mm_y", 64'(bus.mm_y), 64'h0);
    chk("rst_mm_m", 64'(bus.mm_m), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    job(16'd2, 4'b0101, 16'd13);
    job(16'd2, 4'b0000, 16'd13);
    // second start while busy must not disturb the running job
    job(16'd2, 4'b0101, 16'd13);
    d0 = done_cnt;
    repeat (10) @(negedge clk);
    bus.start = 1'b1; bus.base = 16'd7; bus.exp = 4'b1111;
    @(negedge clk);
    scramble();
    wait_idle(5000);
    chk("done_once_with_busy_start", 64'(done_cnt - d0), 64'h1);
    // start held through FIN and the following IDLE cycle: only the IDLE one is taken
    job(16'd5, 4'b0011, 16'd13);
    n = 0;
    while (!bus.done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("fin_reached", 64'(bus.done), 64'h1);
    issue(16'd3, 4'b1001, 16'd13);
    @(negedge clk);
    chk("start_in_fin_ignored", 64'(bus.busy), 64'h0);
    @(negedge clk);
    chk("start_after_fin_taken", 64'(bus.busy), 64'h1);
    scramble();
    wait_idle(5000);
    // reset during the first SQR wait, stale mm_val arrives 2 cycles after release
    job(16'd2, 4'b0101, 16'd13);
    n = 1;
    while (n < 3 && bus.busy) begin
      @(negedge clk);
      if (bus.mm_req) n++;
    end
    chk("sqr_req_seen", 64'(n), 64'h3);
    stale = 1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb_res.delete();
    sb_req.delete();
    exp_done--;
    d0 = done_cnt;
    repeat (12) begin
      @(negedge clk);
      chk("abort_busy", 64'(bus.busy), 64'h0);
      chk("abort_mm_req", 64'(bus.mm_req), 64'h0);
    end
    chk("abort_no_done", 64'(done_cnt - d0), 64'h0);
    chk("abort_model_drained", 64'(pend), 64'h0);
    stale = 0;
    req_cnt = 0;
    lat_min = 1;
    lat_max = 40;
    for (int j = 0; j < 200; j++) begin
      logic [K-1:0] md;
      md = K'(2 * $urandom_range(32767, 1) + 1);
      job(K'($urandom % 32'(md)), E'($urandom), md);
    end
    wait_idle(5000);
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_res.size()), 64'h0);
    chk("done_total", 64'(done_cnt), 64'(exp_done));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mmm_modexp_ctrl.md
MMM_MODEXP_CTRL -- requirements
Module: mmm_modexp_ctrl

Interface
REQ-001 The block SHALL expose parameter K, default 256, giving the modulus/operand width in bits (even, 4..8190).
REQ-002 The block SHALL expose parameter E, default 256, giving the exponent width in bits (1..8191).
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle request to begin an exponentiation; honoured only when busy=0.
REQ-006 base  input  K  base, SHALL be < m; sampled on accepted start.
REQ-007 exp  input  E  exponent; sampled on accepted start.
REQ-008 m  input  K  odd modulus; sampled on accepted start.
REQ-009 r2  input  K  R^2 mod m, R=2^K; sampled on accepted start.
REQ-010 busy  output  1  high from the cycle after an accepted start until the cycle done pulses, inclusive.
REQ-011 done  output  1  one-cycle pulse; result valid from the same cycle.
REQ-012 result  output  K  base^exp mod m; held until the next done.
REQ-013 mm_x, mm_y  output  K each  operands to the external Montgomery multiplier.
REQ-014 mm_m  output  K  modulus to the multiplier; equals the latched m.
REQ-015 mm_req  output  1  one-cycle request pulse to the multiplier.
REQ-016 mm_res  input  K  multiplier result x*y*R^-1 mod m, fully reduced (< m).
REQ-017 mm_val  input  1  one-cycle pulse marking mm_res valid.

Function
REQ-018 The FSM SHALL have states IDLE, CONV_B, CONV_1, SQR, MUL, FROM and FIN, with a WAIT sub-phase in every operation state (CONV_B through FROM).
REQ-019 In each operation state, mm_req SHALL pulse for exactly one cycle on entry, then the WAIT sub-phase SHALL hold until mm_val.
REQ-020 mm_x, mm_y and mm_m SHALL be valid in the mm_req cycle and stable until mm_val is sampled.
REQ-021 mm_val SHALL be sampled only in WAIT, from the cycle after mm_req onward; mm_val in any other cycle SHALL be ignored.
REQ-022 IDLE with start=1: latch the operands, set bit index i=E-1, go to CONV_B; busy=1 next cycle.
REQ-023 CONV_B: (x,y)=(base,r2), result stored in bm (Montgomery base); next CONV_1.
REQ-024 CONV_1: (x,y)=(r2,1), result stored in acc (R mod m); next SQR.
REQ-025 SQR: (x,y)=(acc,acc), result stored in acc; then MUL if exp[i]=1, else decrement i or go to FROM if i=0.
REQ-026 MUL: (x,y)=(acc,bm), result stored in acc; then decrement i, or go to FROM if i=0.
REQ-027 FROM: (x,y)=(acc,1), result loaded into result; next FIN.
REQ-028 FIN SHALL assert done for one cycle, clear busy in the following cycle, and return to IDLE.
REQ-029 The number of mm_req pulses per job SHALL be exactly 3+E+popcount(exp).
REQ-030 Leading zero exponent bits SHALL NOT be skipped; the squarings still run.
REQ-031 exp=0 SHALL produce result=1 (for m>1).
REQ-032 start while busy=1 SHALL be ignored, with no effect on latched operands or progress.
REQ-033 start in the FIN cycle SHALL be ignored; start in the first IDLE cycle after FIN SHALL be accepted.
REQ-034 Changes on base/exp/m/r2 after acceptance SHALL NOT affect the running job.
REQ-035 The block SHALL NOT time out; it waits for mm_val indefinitely.

Reset
REQ-036 On rst_n low: FSM=IDLE; busy, done and mm_req=0; result, mm_x, mm_y, mm_m, acc, bm=0; i=0.
REQ-037 Reset asserted mid-job SHALL abort the job without a done pulse.
REQ-038 An mm_val arriving after reset release for an aborted request SHALL be ignored.

Verification
REQ-039 K=8, E=4, m=13, r2=3, base=2, exp=4'b0101, behavioural multiplier with 5-cycle latency -> 9 mm_req pulses, done once, result=6.
REQ-040 Same setup with exp=0 -> 7 mm_req pulses, result=1.
REQ-041 start pulsed again while busy, with different base -> ignored; result=6, exactly one done.
REQ-042 rst_n low during SQR WAIT, then the multiplier's stale mm_val 2 cycles after release -> no done, busy=0, mm_req stays 0.
REQ-043 Multiplier latency varied randomly 1..40 cycles, 200 random (base<m, exp) jobs at K=16 -> result matches reference modexp; operands stable during every WAIT.
